ext_share_arbiter: RTL and testbench

EXT_SHARE_ARBITER -- requirements
Module: ext_share_arbiter

---
 rtl/ext_share_arbiter_pkg.sv | 24 ++
 rtl/ext_share_arbiter_sign_extend.sv | 14 +
 rtl/ext_share_arbiter.sv | 131 +++++++++++++
 tb/tb_ext_share_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_share_arbiter_pkg.sv
// Shared definitions for the extension-unit arbiter: FSM encoding,
// default datapath widths and a wrap-around index helper.
package ext_share_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = 18;

  // Advance a requester index by one, wrapping after the last requester.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int num);
    logic [1:0] nxt;
    if (int'(idx) >= (num - 1)) begin
      nxt = 2'b00;
    end else begin
      nxt = idx + 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ext_share_arbiter_sign_extend.sv
// Parameterised two's-complement sign extension from IN_W to OUT_W bits.
module sign_extend_n
  import ext_share_arbiter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  assign out_val = {{(OUT_W - IN_W){in_val[IN_W-1]}}, in_val};

endmodule

// File: rtl/ext_share_arbiter.sv
// Round-robin arbiter sharing one sign-extension unit among NUM_REQ requesters;
// the extended result is held with valid/ready until the consumer accepts it.
module ext_share_arbiter
  import ext_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*IN_W-1:0] imm,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [1:0]              out_id
);

  arb_state_t       state_r;
  arb_state_t       state_s;
  logic [1:0]       ptr_r;
  logic [1:0]       ptr_s;
  logic [1:0]       out_id_r;
  logic [1:0]       id_s;
  logic [1:0]       grant_s;
  logic             found_s;
  logic             handshake_s;
  logic [IN_W-1:0]  imm_sel_s;
  logic [OUT_W-1:0] ext_s;
  logic [OUT_W-1:0] out_data_r;
  logic [OUT_W-1:0] data_s;

  // Round-robin search: first pending request at or after ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    grant_s = 2'b00;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && req[i] && (i == ((int'(ptr_r) + k) % NUM_REQ))) begin
          found_s = 1'b1;
          grant_s = 2'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Select the granted requester's immediate for the shared extender.
  always_comb begin
    imm_sel_s = {IN_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s == 2'(i)) begin
        imm_sel_s = imm[i*IN_W +: IN_W];
      end else begin
        imm_sel_s = imm_sel_s;
      end
    end
  end

  sign_extend_n #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sext (
    .in_val  (imm_sel_s),
    .out_val (ext_s)
  );

  assign handshake_s = (state_r == HOLD) && out_ready;

  // Acknowledge only the owner of the accepted result, in the accept cycle.
  always_comb begin
    ack = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = handshake_s && (out_id_r == 2'(i));
    end
  end

  // Next-state logic: grant from IDLE, release on handshake from HOLD.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    data_s  = out_data_r;
    id_s    = out_id_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = HOLD;
          data_s  = ext_s;
          id_s    = grant_s;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        // Requests are ignored here; the held result waits for the consumer.
        if (out_ready) begin
          state_s = IDLE;
          ptr_s   = wrap_inc(out_id_r, NUM_REQ);
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pointer and held-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= 2'b00;
      out_data_r <= {OUT_W{1'b0}};
      out_id_r   <= 2'b00;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      out_data_r <= data_s;
      out_id_r   <= id_s;
    end
  end

  assign out_valid = (state_r == HOLD);
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;

endmodule

// File: tb/tb_ext_share_arbiter.sv
// Directed bench for ext_share_arbiter with a transaction-level reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_ext_share_arbiter;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int OW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*IW-1:0] imm;
  logic [N-1:0]  ack;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_id;

  int n_pass  = 0;
  int n_total = 0;

  ext_share_arbiter #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .imm       (imm),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a held result (value, owner) and the round-robin start.
  logic          m_hold = 1'b0;
  logic [OW-1:0] m_val  = '0;
  int            m_id   = 0;
  int            m_ptr  = 0;
  int            cyc    = 0;
  int            m_grants[$];
  int            m_gcyc[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] sext(input logic [IW-1:0] v);
    int s;
    s = int'(v);
    if (s >= (1 << (IW - 1))) s = s - (1 << IW);
    return OW'(s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 1'b0;
      m_val  <= '0;
      m_id   <= 0;
      m_ptr  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_hold) begin
        if (out_ready) begin
          m_hold <= 1'b0;
          m_ptr  <= (m_id + 1) % N;
        end
      end else if (rr_pick(req, m_ptr) >= 0) begin
        m_hold <= 1'b1;
        m_id   <= rr_pick(req, m_ptr);
        m_val  <= sext(imm[rr_pick(req, m_ptr)*IW +: IW]);
        m_grants.push_back(rr_pick(req, m_ptr));
        m_gcyc.push_back(cyc);
      end
    end
  end

  logic chk_en = 1'b0;
  logic [N-1:0] last_ack;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid", 32'(out_valid), 32'(m_hold));
      check("cmp_data", 32'(out_data), 32'(m_val));
      check("cmp_id", 32'(out_id), 32'(m_id));
      check("cmp_ack", 32'(ack), (m_hold && out_ready) ? (32'd1 << m_id) : 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
    last_ack = ack;
    @(posedge clk);
    #1;
  endtask

  logic [OW-1:0] held;
  int base;

  initial begin
    rst = 1'b1; req = '0; imm = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    chk_en = 1'b1;

    // Negative immediate from requester 0
    rst = 1'b0; imm[3:0] = 4'b1000; req = 3'b001; out_ready = 1'b1;
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h3FFF8);
    check("t1_id", 32'(out_id), 32'd0);
    check("t1_ack", 32'(ack), 32'b001);
    tick();
    check("t1_ackseen", 32'(last_ack), 32'b001);
    req = req & ~last_ack;

    // Positive and zero immediates from requester 1
    imm[7:4] = 4'b0111; req = 3'b010;
    tick();
    check("t2_data7", 32'(out_data), 32'h00007);
    check("t2_id", 32'(out_id), 32'd1);
    tick(); req = req & ~last_ack;
    imm[7:4] = 4'b0000; req = 3'b010;
    tick();
    check("t2_data0", 32'(out_data), 32'h00000);
    tick(); req = req & ~last_ack;

    // All three requesting from a fresh reset: order 0,1,2 with idle gaps
    rst = 1'b1; tick(); rst = 1'b0;
    imm = {4'h9, 4'h5, 4'hA};
    base = m_grants.size();
    req = 3'b111;
    for (int t = 0; t < 20 && !(req == 3'b000 && !out_valid); t++) begin
      tick();
      req = req & ~last_ack;
    end
    check("t3_done", 32'(req == 3'b000 && !out_valid), 32'd1);
    check("t3_count", 32'(m_grants.size() - base), 32'd3);
    if (m_grants.size() - base == 3) begin
      check("t3_g0", 32'(m_grants[base]), 32'd0);
      check("t3_g1", 32'(m_grants[base+1]), 32'd1);
      check("t3_g2", 32'(m_grants[base+2]), 32'd2);
      check("t3_gap01", 32'(m_gcyc[base+1] - m_gcyc[base]), 32'd2);
      check("t3_gap12", 32'(m_gcyc[base+2] - m_gcyc[base+1]), 32'd2);
    end

    // Back-pressure: requester 0 held for five cycles, then requester 2
    imm[3:0] = 4'h5; req = 3'b101; out_ready = 1'b0;
    tick();
    held = out_data;
    check("t4_data", 32'(held), 32'h00005);
    for (int t = 0; t < 5; t++) begin
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_id", 32'(out_id), 32'd0);
      check("t4_stable", 32'(out_data), 32'(held));
      check("t4_noack", 32'(ack), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    check("t4_ack", 32'(ack), 32'b001);
    tick(); req = req & ~last_ack;
    check("t4_idle", 32'(out_valid), 32'd0);
    tick();
    check("t4_g2_id", 32'(out_id), 32'd2);
    check("t4_g2_valid", 32'(out_valid), 32'd1);
    tick(); req = req & ~last_ack;

    // Reset while holding a result
    out_ready = 1'b0; imm[3:0] = 4'h3; req = 3'b001;
    tick();
    check("t5_hold", 32'(out_valid), 32'd1);
    #1; rst = 1'b1; #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    tick();
    rst = 1'b0; req = 3'b110;
    tick();
    check("t5_id", 32'(out_id), 32'd1);
    out_ready = 1'b1;
    tick(); req = req & ~last_ack;
    check("t5_ack1", 32'(last_ack), 32'b010);
    tick(); tick(); req = req & ~last_ack;

    // Requester drops req while its result is held
    imm[3:0] = 4'b1010; req = 3'b001; out_ready = 1'b0;
    tick();
    req = 3'b000;
    tick(); tick();
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_id", 32'(out_id), 32'd0);
    check("t6_data", 32'(out_data), 32'h3FFFA);
    out_ready = 1'b1; #1;
    check("t6_ack", 32'(ack), 32'b001);
    tick();
    check("t6_ackseen", 32'(last_ack), 32'b001);
    tick();
    check("t6_idle_valid", 32'(out_valid), 32'd0);
    check("t6_idle_ack", 32'(ack), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
